// File: rtl/alu_pkg.sv
// Opcodes, FSM encoding and flag bit positions for the accumulator sequencer.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_LOAD = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_V = 1;
  localparam int FLG_C = 0;

  function automatic logic op_legal(input logic [2:0] op);
    return (op != 3'd2) && (op != 3'd3);
  endfunction

endpackage

// File: rtl/alu_flag_unit.sv
// Combinational write-back value and next {Z,N,V,C} for one instruction.
module alu_flag_unit
  import alu_pkg::*;
(
  input  logic [2:0] op,
  input  logic [3:0] alu_y,
  input  logic       alu_cout,
  input  logic       alu_ovf,
  input  logic [3:0] imm,
  output logic [3:0] acc_nxt,
  output logic [3:0] flags_nxt,
  output logic       legal
);

  logic v_nxt;
  logic c_nxt;

  always_comb begin
    acc_nxt = alu_y;
    v_nxt   = 1'b0;
    c_nxt   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        v_nxt = alu_ovf;
        c_nxt = alu_cout;
      end
      OP_LOAD: acc_nxt = imm;
      default: ;
    endcase
    flags_nxt        = 4'b0000;
    flags_nxt[FLG_Z] = (acc_nxt == 4'h0);
    flags_nxt[FLG_N] = acc_nxt[3];
    flags_nxt[FLG_V] = v_nxt;
    flags_nxt[FLG_C] = c_nxt;
    legal            = op_legal(op);
  end

endmodule

// File: rtl/alu_acc_seq.sv
// Accumulator sequencer driving an external 4-bit ALU: IDLE accept, EXEC write-back, DONE present.
// Optional ALU_ACC_CHAIN_EN: cin=1 on ADD/SUB feeds the stored C flag for multi-precision chains.
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter logic [3:0] RESET_ACC = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_op,
  input  logic [3:0] in_imm,
  input  logic       in_cin,
  input  logic       acc_clr,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_cin,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_y,
  input  logic       alu_cout,
  input  logic       alu_ovf,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [3:0] flags,
  output logic       err
);

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [3:0] imm_q, imm_d;
  logic       cin_q, cin_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] flags_q, flags_d;
  logic       err_q, err_d;

  logic [3:0] acc_nxt;
  logic [3:0] flags_nxt;
  logic       legal;
  logic       cin_sel;

  alu_flag_unit u_flag (
    .op        (op_q),
    .alu_y     (alu_y),
    .alu_cout  (alu_cout),
    .alu_ovf   (alu_ovf),
    .imm       (imm_q),
    .acc_nxt   (acc_nxt),
    .flags_nxt (flags_nxt),
    .legal     (legal)
  );

`ifdef ALU_ACC_CHAIN_EN
  assign cin_sel = (cin_q && (op_q == OP_ADD || op_q == OP_SUB)) ? flags_q[FLG_C] : cin_q;
`else
  assign cin_sel = cin_q;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    imm_d   = imm_q;
    cin_d   = cin_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          imm_d   = in_imm;
          cin_d   = in_cin;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        if (legal) begin
          acc_d   = acc_nxt;
          flags_d = flags_nxt;
        end else begin
          err_d = 1'b1;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Clear wins over a same-cycle write-back but never stalls the FSM.
    if (acc_clr) begin
      acc_d   = RESET_ACC;
      flags_d = 4'b0000;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      imm_q   <= 4'h0;
      cin_q   <= 1'b0;
      acc_q   <= RESET_ACC;
      flags_q <= 4'b0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      cin_q   <= cin_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign alu_a     = acc_q;
  assign alu_b     = imm_q;
  assign alu_op    = (state_q == S_EXEC) ? op_q : 3'b000;
  assign alu_cin   = (state_q == S_EXEC) ? cin_sel : 1'b0;
  assign res_data  = acc_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Bench for alu_acc_seq: reference ALU, vector table, corner sequences, random vs arithmetic model.
module tb_alu_acc_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [2:0] in_op;
  logic [3:0] in_imm;
  logic       in_cin, acc_clr;
  logic [3:0] alu_a, alu_b;
  logic       alu_cin;
  logic [2:0] alu_op;
  logic [3:0] alu_y;
  logic       alu_cout, alu_ovf;
  logic       res_valid, res_ready;
  logic [3:0] res_data, flags;
  logic       err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [3:0] macc;
  logic [3:0] mflags;
  logic       merr;

  always #5 clk = ~clk;

  alu_acc_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .in_cin(in_cin), .acc_clr(acc_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .flags(flags), .err(err)
  );

  // Stand-in for the external ALU.
  always_comb begin
    logic [4:0] wide;
    logic signed [5:0] sr;
    wide     = 5'd0;
    sr       = 6'sd0;
    alu_y    = 4'h0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (alu_op)
      3'd0: begin
        wide     = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
        sr       = $signed({{2{alu_a[3]}}, alu_a}) + $signed({{2{alu_b[3]}}, alu_b}) + $signed({5'b0, alu_cin});
        alu_y    = wide[3:0];
        alu_cout = wide[4];
        alu_ovf  = (sr > 6'sd7) || (sr < -6'sd8);
      end
      3'd1: begin
        wide     = {1'b0, alu_a} - {1'b0, alu_b} - {4'b0, alu_cin};
        sr       = $signed({{2{alu_a[3]}}, alu_a}) - $signed({{2{alu_b[3]}}, alu_b}) - $signed({5'b0, alu_cin});
        alu_y    = wide[3:0];
        alu_cout = wide[4];
        alu_ovf  = (sr > 6'sd7) || (sr < -6'sd8);
      end
      3'd4: alu_y = alu_a & alu_b;
      3'd5: alu_y = alu_a | alu_b;
      3'd6: alu_y = alu_a ^ alu_b;
      default: alu_y = 4'h0;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int to_s(input logic [3:0] x);
    return (x >= 4'd8) ? int'(x) - 16 : int'(x);
  endfunction

  function automatic logic model_cin(input logic [2:0] op, input logic cin);
`ifdef ALU_ACC_CHAIN_EN
    if (cin && (op == 3'd0 || op == 3'd1)) return mflags[0];
`endif
    return (op == 3'd2 || op == 3'd3) ? cin : cin;
  endfunction

  task automatic model_step(input logic [2:0] op, input logic [3:0] imm, input logic cin);
    int u, s;
    logic [3:0] y;
    logic c, v;
    c = 1'b0; v = 1'b0; y = 4'h0;
    case (op)
      3'd0: begin
        u = int'(macc) + int'(imm) + int'(cin);
        y = 4'(u % 16); c = (u > 15);
        s = to_s(macc) + to_s(imm) + int'(cin); v = (s > 7) || (s < -8);
      end
      3'd1: begin
        u = int'(macc) - int'(imm) - int'(cin);
        y = 4'((u + 32) % 16); c = (u < 0);
        s = to_s(macc) - to_s(imm) - int'(cin); v = (s > 7) || (s < -8);
      end
      3'd4: y = macc & imm;
      3'd5: y = macc | imm;
      3'd6: y = macc ^ imm;
      3'd7: y = imm;
      default: begin
        merr = 1'b1;
        return;
      end
    endcase
    macc   = y;
    mflags = {(y == 4'h0), y[3], v, c};
  endtask

  // Caller is at a falling edge; returns the presented result.
  task automatic do_instr(input logic [2:0] op, input logic [3:0] imm, input logic cin,
                          input int stall, input logic clr_exec,
                          output logic [3:0] d, output logic [3:0] f, output logic e);
    int n;
    logic ecin;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_op = op; in_imm = imm; in_cin = cin;
    ecin = model_cin(op, cin);
    @(negedge clk);
    // Junk offered while busy must be ignored.
    in_valid = 1'b1; in_op = 3'($urandom); in_imm = 4'($urandom); in_cin = 1'($urandom);
    check("exec_in_ready", in_ready, 0);
    check("exec_res_valid", res_valid, 0);
    check("exec_alu_op", alu_op, op);
    check("exec_alu_cin", alu_cin, ecin);
    check("exec_alu_a", alu_a, macc);
    check("exec_alu_b", alu_b, imm);
    acc_clr = clr_exec;
    model_step(op, imm, ecin);
    if (clr_exec) begin
      macc = 4'h0; mflags = 4'h0; merr = 1'b0;
    end
    @(negedge clk);
    acc_clr = 1'b0;
    check("done_res_valid", res_valid, 1);
    check("done_in_ready", in_ready, 0);
    d = res_data; f = flags; e = err;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", res_valid, 1);
      check("stall_data", res_data, d);
      check("stall_flags", flags, f);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("back_idle_ready", in_ready, 1);
    check("back_idle_valid", res_valid, 0);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] imm;
    logic       cin;
    int         stall;
    logic [3:0] data;
    logic [3:0] flg;
    logic       e;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [3:0] d, f;
    logic e;
    tbl[0]  = '{3'd7, 4'h7, 1'b0, 0, 4'h7, 4'b0000, 1'b0};
    tbl[1]  = '{3'd7, 4'hF, 1'b0, 0, 4'hF, 4'b0100, 1'b0};
    tbl[2]  = '{3'd0, 4'h1, 1'b0, 0, 4'h0, 4'b1001, 1'b0};
    tbl[3]  = '{3'd7, 4'h5, 1'b0, 0, 4'h5, 4'b0000, 1'b0};
    tbl[4]  = '{3'd6, 4'h5, 1'b0, 4, 4'h0, 4'b1000, 1'b0};
    tbl[5]  = '{3'd7, 4'h3, 1'b0, 0, 4'h3, 4'b0000, 1'b0};
    tbl[6]  = '{3'd1, 4'h5, 1'b0, 1, 4'hE, 4'b0101, 1'b0};
    tbl[7]  = '{3'd7, 4'h7, 1'b0, 0, 4'h7, 4'b0000, 1'b0};
    tbl[8]  = '{3'd0, 4'h1, 1'b0, 0, 4'h8, 4'b0110, 1'b0};
    tbl[9]  = '{3'd7, 4'hC, 1'b0, 0, 4'hC, 4'b0100, 1'b0};
    tbl[10] = '{3'd4, 4'h6, 1'b0, 0, 4'h4, 4'b0000, 1'b0};
    tbl[11] = '{3'd5, 4'h3, 1'b0, 2, 4'h7, 4'b0000, 1'b0};
    tbl[12] = '{3'd7, 4'hA, 1'b0, 0, 4'hA, 4'b0100, 1'b0};
    tbl[13] = '{3'd3, 4'h1, 1'b0, 0, 4'hA, 4'b0100, 1'b1};
    tbl[14] = '{3'd0, 4'h1, 1'b0, 0, 4'hB, 4'b0100, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_imm = 4'h0; in_cin = 1'b0;
    acc_clr = 1'b0; res_ready = 1'b0;
    macc = 4'h0; mflags = 4'h0; merr = 1'b0;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_flags", flags, 0);
    check("rst_err", err, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_cin", alu_cin, 0);
    check("rst_alu_op", alu_op, 0);
    #9 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      do_instr(tbl[i].op, tbl[i].imm, tbl[i].cin, tbl[i].stall, 1'b0, d, f, e);
      check($sformatf("tbl%0d_data", i), d, tbl[i].data);
      check($sformatf("tbl%0d_flags", i), f, tbl[i].flg);
      check($sformatf("tbl%0d_err", i), e, tbl[i].e);
    end

    // Clear from IDLE drops the sticky error.
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    macc = 4'h0; mflags = 4'h0; merr = 1'b0;
    check("clr_idle_data", res_data, 0);
    check("clr_idle_flags", flags, 0);
    check("clr_idle_err", err, 0);
    check("clr_idle_ready", in_ready, 1);

    // Clear during EXEC beats the write-back.
    do_instr(3'd7, 4'h6, 1'b0, 0, 1'b0, d, f, e);
    check("pre_clr_data", d, 4'h6);
    do_instr(3'd0, 4'h2, 1'b0, 1, 1'b1, d, f, e);
    check("clr_exec_data", d, 0);
    check("clr_exec_flags", f, 0);
    check("clr_exec_err", e, 0);

    // Asynchronous reset in the middle of EXEC.
    do_instr(3'd7, 4'h3, 1'b0, 0, 1'b0, d, f, e);
    in_valid = 1'b1; in_op = 3'd7; in_imm = 4'h9; in_cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_exec", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_data", res_data, 0);
    check("mid_rst_flags", flags, 0);
    check("mid_rst_alu_op", alu_op, 0);
    check("mid_rst_alu_b", alu_b, 0);
    #2 rst_n = 1'b1;
    macc = 4'h0; mflags = 4'h0; merr = 1'b0;
    @(negedge clk);
    do_instr(3'd7, 4'h9, 1'b0, 0, 1'b0, d, f, e);
    check("post_rst_data", d, 4'h9);
    check("post_rst_flags", f, 4'b0100);

`ifdef ALU_ACC_CHAIN_EN
    do_instr(3'd7, 4'hF, 1'b0, 0, 1'b0, d, f, e);
    do_instr(3'd0, 4'h1, 1'b0, 0, 1'b0, d, f, e);
    check("chain_c_set", f[0], 1);
    do_instr(3'd0, 4'h0, 1'b1, 0, 1'b0, d, f, e);
    check("chain_data", d, 4'h1);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [3:0] imm;
      logic cin, clr;
      op  = 3'($urandom_range(0, 7));
      imm = 4'($urandom);
      cin = 1'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      do_instr(op, imm, cin, $urandom_range(0, 2), clr, d, f, e);
      check("rnd_data", d, macc);
      check("rnd_flags", f, mflags);
      check("rnd_err", e, merr);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
